// File: rtl/multicycle_control_fsm_pkg.sv
// MiniMIPS multi-cycle control: shared encodings.
// States, opcodes, ALU ops, mux selects and the control bundle.
package mini_mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    EXEC_R   = S_EXEC_R,
    EXEC_I   = S_EXEC_I,
    WB_R     = S_WB_R,
    WB_I     = S_WB_I,
    MEM_ADDR = S_MEM_ADDR,
    MEM_RD   = S_MEM_RD,
    MEM_WR   = S_MEM_WR,
    WB_MEM   = S_WB_MEM,
    BRANCH   = S_BRANCH,
    JUMP     = S_JUMP,
    HALT     = S_HALT
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;
  localparam logic [3:0] OP_J     = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_FUNC = 3'b111;

  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_TWO  = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_IMM2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic state_e decode_next(
    input logic [3:0] op
  );
    case (op)
      OP_RTYPE:                 return EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI: return EXEC_I;
      OP_LW, OP_SW:             return MEM_ADDR;
      OP_BEQ, OP_BNE:           return BRANCH;
      OP_J:                     return JUMP;
      OP_HALT:                  return HALT;
      default:                  return FETCH;
    endcase
  endfunction

  function automatic logic is_illegal(
    input logic [3:0] op
  );
    return (op > OP_J) && (op != OP_HALT);
  endfunction

  function automatic logic [2:0] imm_alu_op(
    input logic [3:0] op
  );
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the MiniMIPS sequencer and datapath.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_fsm_if #(
  parameter int COUNT_W = 16
);
  logic [3:0]         opcode;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_write;
  logic               pc_write;
  logic               pc_write_cond;
  logic               branch_ne;
  logic [1:0]         pc_source;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               illegal_op;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord,
    output ir_write, pc_write,
    output pc_write_cond, branch_ne,
    output pc_source, alu_src_a,
    output alu_src_b, alu_op,
    output reg_dst, mem_to_reg,
    output reg_write, illegal_op,
    output halted, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord,
    input  ir_write, pc_write,
    input  pc_write_cond, branch_ne,
    input  pc_source, alu_src_a,
    input  alu_src_b, alu_op,
    input  reg_dst, mem_to_reg,
    input  reg_write, illegal_op,
    input  halted, instr_count
  );
endinterface

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational map of (state, opcode, mem_ready) to controls.
// Only ir_write/pc_write in FETCH depend on mem_ready.
module ctrl_output_decoder
  import mini_mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control word, everything else held at 0
  always_comb begin
    ctrl = CTRL_IDLE;
    unique case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRC_B_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = is_illegal(opcode);
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNC;
      end
      WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_OUT;
        ctrl.branch_ne     = opcode[0];
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JMP;
      end
      HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// MiniMIPS multi-cycle main control unit.
// State register, next-state logic and retired-instruction counter.
module multicycle_control_fsm
  import mini_mips_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_e             state;
  state_e             state_nxt;
  logic               retire;
  logic [COUNT_W-1:0] count;
  ctrl_t              ctrl;
  ctrl_t              out;

  // State register and retire counter, reset abandons any access
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) count <= count + 1'b1;
    end
  end

  // Next state; retire marks the return to FETCH after real work
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      FETCH:    if (bus.mem_ready) state_nxt = DECODE;
      DECODE:   state_nxt = decode_next(bus.opcode);
      EXEC_R:   state_nxt = WB_R;
      EXEC_I:   state_nxt = WB_I;
      MEM_ADDR: state_nxt = bus.opcode[0] ? MEM_WR : MEM_RD;
      MEM_RD:   if (bus.mem_ready) state_nxt = WB_MEM;
      MEM_WR: begin
        if (bus.mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      WB_R, WB_I, WB_MEM, BRANCH, JUMP: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = FETCH;
    endcase
  end

  ctrl_output_decoder u_dec (
    .state     (state),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset forces every output low in the same cycle
  always_comb begin
    out = reset ? CTRL_IDLE : ctrl;
  end

  assign bus.mem_req       = out.mem_req;
  assign bus.mem_we        = out.mem_we;
  assign bus.iord          = out.iord;
  assign bus.ir_write      = out.ir_write;
  assign bus.pc_write      = out.pc_write;
  assign bus.pc_write_cond = out.pc_write_cond;
  assign bus.branch_ne     = out.branch_ne;
  assign bus.pc_source     = out.pc_source;
  assign bus.alu_src_a     = out.alu_src_a;
  assign bus.alu_src_b     = out.alu_src_b;
  assign bus.alu_op        = out.alu_op;
  assign bus.reg_dst       = out.reg_dst;
  assign bus.mem_to_reg    = out.mem_to_reg;
  assign bus.reg_write     = out.reg_write;
  assign bus.illegal_op    = out.illegal_op;
  assign bus.halted        = out.halted;
  assign bus.instr_count   = reset ? '0 : count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle scoreboard of controls
// and counter, with a 4-bit counter twin for wrap checking.
module tb_multicycle_control_fsm;

  typedef enum {
    T_RST, T_F, T_D, T_XR, T_WR, T_XI, T_WI,
    T_MA, T_MR, T_MW, T_WM, T_BR, T_J, T_H
  } st_t;

  typedef struct {
    st_t         s;
    logic [19:0] word;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  logic [31:0] exp_cnt;
  int errors;
  int checks;

  multicycle_control_fsm_if #(.COUNT_W(16)) bus ();
  multicycle_control_fsm_if #(.COUNT_W(4))  bus4 ();

  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  multicycle_control_fsm #(.COUNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  multicycle_control_fsm #(.COUNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [19:0] obs = {
    bus.mem_req, bus.mem_we, bus.iord, bus.ir_write,
    bus.pc_write, bus.pc_write_cond, bus.branch_ne,
    bus.pc_source, bus.alu_src_a, bus.alu_src_b,
    bus.alu_op, bus.reg_dst, bus.mem_to_reg,
    bus.reg_write, bus.illegal_op, bus.halted
  };

  wire [19:0] obs4 = {
    bus4.mem_req, bus4.mem_we, bus4.iord, bus4.ir_write,
    bus4.pc_write, bus4.pc_write_cond, bus4.branch_ne,
    bus4.pc_source, bus4.alu_src_a, bus4.alu_src_b,
    bus4.alu_op, bus4.reg_dst, bus4.mem_to_reg,
    bus4.reg_write, bus4.illegal_op, bus4.halted
  };

  function automatic logic [19:0] exp_word(
    input st_t s, input logic [3:0] op, input logic rdy
  );
    logic rq, we, io, irw, pcw, pcc, bn, sa;
    logic rd, m2r, rw, ill, hlt;
    logic [1:0] ps, sbsel;
    logic [2:0] aop;
    rq = 0; we = 0; io = 0; irw = 0; pcw = 0; pcc = 0;
    bn = 0; sa = 0; rd = 0; m2r = 0; rw = 0; ill = 0;
    hlt = 0; ps = 2'b00; sbsel = 2'b00; aop = 3'b000;
    case (s)
      T_F: begin
        rq = 1; sbsel = 2'b01; irw = rdy; pcw = rdy;
      end
      T_D: begin
        sbsel = 2'b11;
        ill = !(op <= 4'd8 || op == 4'hF);
      end
      T_XR: begin sa = 1; aop = 3'b111; end
      T_WR: begin rd = 1; rw = 1; end
      T_XI: begin
        sa = 1; sbsel = 2'b10;
        aop = (op == 4'd2) ? 3'b010 :
              (op == 4'd3) ? 3'b011 : 3'b000;
      end
      T_WI: rw = 1;
      T_MA: begin sa = 1; sbsel = 2'b10; end
      T_MR: begin rq = 1; io = 1; end
      T_MW: begin rq = 1; we = 1; io = 1; end
      T_WM: begin m2r = 1; rw = 1; end
      T_BR: begin
        sa = 1; aop = 3'b001; pcc = 1;
        ps = 2'b01; bn = op[0];
      end
      T_J: begin pcw = 1; ps = 2'b10; end
      T_H: hlt = 1;
      default: ;
    endcase
    return {rq, we, io, irw, pcw, pcc, bn, ps, sa, sbsel,
            aop, rd, m2r, rw, ill, hlt};
  endfunction

  task automatic step(input st_t s, input logic rdy);
    exp_t e;
    exp_t g;
    reset = (s == T_RST);
    bus.mem_ready = rdy;
    e.s    = s;
    e.word = (s == T_RST) ? 20'h0 : exp_word(s, bus.opcode, rdy);
    e.cnt  = (s == T_RST) ? 32'd0 : exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty state=%s", s.name());
    end else begin
      g = sb.pop_front();
      checks++;
      if (obs !== g.word) begin
        errors++;
        $display("FAIL ctrl16 state=%s got=%h want=%h",
                 g.s.name(), obs, g.word);
      end
      checks++;
      if (bus.instr_count !== g.cnt[15:0]) begin
        errors++;
        $display("FAIL count16 state=%s got=%0d want=%0d",
                 g.s.name(), bus.instr_count, g.cnt[15:0]);
      end
      checks++;
      if (obs4 !== g.word) begin
        errors++;
        $display("FAIL ctrl4 state=%s got=%h want=%h",
                 g.s.name(), obs4, g.word);
      end
      checks++;
      if (bus4.instr_count !== g.cnt[3:0]) begin
        errors++;
        $display("FAIL count4 state=%s got=%0d want=%0d",
                 g.s.name(), bus4.instr_count, g.cnt[3:0]);
      end
    end
    @(posedge clk);
    #1;
    if (s == T_RST) exp_cnt = 0;
    else if (s inside {T_WR, T_WI, T_WM, T_BR, T_J}) exp_cnt++;
    else if (s == T_MW && rdy) exp_cnt++;
    reset = 1'b0;
  endtask

  task automatic run_instr(
    input logic [3:0] op, input int fwait, input int mwait
  );
    bus.opcode = op;
    repeat (fwait) step(T_F, 1'b0);
    step(T_F, 1'b1);
    step(T_D, 1'b1);
    case (op)
      4'd0: begin step(T_XR, 1'b1); step(T_WR, 1'b1); end
      4'd1, 4'd2, 4'd3: begin
        step(T_XI, 1'b1); step(T_WI, 1'b1);
      end
      4'd4: begin
        step(T_MA, 1'b1);
        repeat (mwait) step(T_MR, 1'b0);
        step(T_MR, 1'b1);
        step(T_WM, 1'b1);
      end
      4'd5: begin
        step(T_MA, 1'b1);
        repeat (mwait) step(T_MW, 1'b0);
        step(T_MW, 1'b1);
      end
      4'd6, 4'd7: step(T_BR, 1'b1);
      4'd8: step(T_J, 1'b1);
      4'd15: for (int i = 0; i < mwait; i++) step(T_H, i[0]);
      default: ;
    endcase
  endtask

  task automatic test_reset;
    bus.opcode = 4'd0;
    step(T_RST, 1'b1);
    step(T_RST, 1'b0);
  endtask

  task automatic test_rtype;
    run_instr(4'd0, 0, 0);
  endtask

  task automatic test_itype;
    run_instr(4'd1, 1, 0);
    run_instr(4'd2, 0, 0);
    run_instr(4'd3, 0, 0);
  endtask

  task automatic test_lw_waits;
    run_instr(4'd4, 2, 3);
  endtask

  task automatic test_sw;
    run_instr(4'd5, 0, 0);
    run_instr(4'd5, 1, 2);
  endtask

  task automatic test_branch_jump;
    run_instr(4'd6, 0, 0);
    run_instr(4'd7, 0, 0);
    run_instr(4'd8, 0, 0);
  endtask

  task automatic test_illegal;
    run_instr(4'hA, 0, 0);
    run_instr(4'h9, 0, 0);
    run_instr(4'hE, 0, 0);
    run_instr(4'd0, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [11];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'hA, 4'hC};
    for (int i = 0; i < 24; i++) begin
      run_instr(ops[$urandom_range(0, 10)],
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_halt;
    run_instr(4'hF, 0, 6);
    step(T_RST, 1'b1);
    run_instr(4'd8, 0, 0);
  endtask

  task automatic test_wrap;
    step(T_RST, 1'b0);
    for (int i = 0; i < 16; i++) run_instr(4'd8, 0, 0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.instr_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap4 got=%0d want=0", bus4.instr_count);
    end
    checks++;
    if (bus.instr_count !== 16'd16) begin
      errors++;
      $display("FAIL wrap16 got=%0d want=16", bus.instr_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mem_wr;
    bus.opcode = 4'd5;
    step(T_F, 1'b1);
    step(T_D, 1'b1);
    step(T_MA, 1'b1);
    step(T_MW, 1'b0);
    step(T_MW, 1'b0);
    step(T_RST, 1'b0);
    run_instr(4'd0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 4'd0;
    bus.mem_ready = 1'b0;
    exp_cnt = 0;
    errors = 0;
    checks = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_lw_waits();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_wrap();
    test_reset_mem_wr();
    run_instr(4'd0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
